// File: rtl/alu_lanes_pkg.sv
// rtl/alu_lanes_pkg.sv - shared lane types, state encoding and broadcast helper for alu_lanes_seq
package alu_lanes_pkg;

    localparam int LANES = 6;
    localparam int LW    = 8;
    localparam int VW    = LANES * LW;
    localparam int FW    = 2 * LANES;

    typedef logic [LANES-1:0][LW-1:0] vec_t;
    typedef logic [1:0][LANES-1:0]    flags_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WAIT_A,
        EXEC,
        DONE
    } seq_state_t;

    function automatic vec_t lane_bcast(input logic [LW-1:0] b);
        return {LANES{b}};
    endfunction

endpackage

// File: rtl/alu_lanes_seq.sv
// rtl/alu_lanes_seq.sv - vector command sequencer for the 6-lane ALU; optional B broadcast via ALU_LANES_SEQ_BCAST_EN
module alu_lanes_seq #(
    parameter int AW       = 8,
    parameter int LANES    = 6,
    parameter int LW       = 8,
    parameter int MAXLEN_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [AW-1:0]         cmd_src_a,
    input  logic [AW-1:0]         cmd_src_b,
    input  logic [AW-1:0]         cmd_dst,
    input  logic [MAXLEN_W-1:0]   cmd_len,
    input  logic                  cmd_bcast,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [LANES*LW-1:0]   mem_rd_data,
    output logic                  mem_wr_en,
    output logic [AW-1:0]         mem_wr_addr,
    output logic [LANES*LW-1:0]   mem_wr_data,
    output logic [LANES*LW-1:0]   alu_src_a,
    output logic [LANES*LW-1:0]   alu_src_b,
    output logic [2:0]            alu_ctrl,
    input  logic [LANES*LW-1:0]   alu_result,
    input  logic [2*LANES-1:0]    alu_flags,
    output logic                  busy,
    output logic                  done,
    output logic [2*LANES-1:0]    flags_out
);
    import alu_lanes_pkg::*;

    seq_state_t            state, state_nx;
    logic [2:0]            op_q;
    logic [AW-1:0]         a_ptr, b_ptr, d_ptr;
    logic [MAXLEN_W-1:0]   rem;
    vec_t                  opa;
    vec_t                  b_eff;
    flags_t                acc;
    flags_t                flags_q;

`ifdef ALU_LANES_SEQ_BCAST_EN
    logic                  bcast_q;
    logic                  first_q;
    logic [LW-1:0]         opb_scalar;

    // On beat 0 the scalar is still on the read bus; later beats use the latched copy.
    assign b_eff = bcast_q ? lane_bcast(first_q ? mem_rd_data[LW-1:0] : opb_scalar)
                           : vec_t'(mem_rd_data);
`else
    logic                  unused_bcast;

    assign unused_bcast = cmd_bcast;
    assign b_eff        = vec_t'(mem_rd_data);
`endif

    assign flags_out = flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_ctrl    = op_q;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nx = (cmd_len == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = a_ptr;
`ifdef ALU_LANES_SEQ_BCAST_EN
                state_nx    = (bcast_q && !first_q) ? WAIT_A : RD_B;
`else
                state_nx    = RD_B;
`endif
            end
            RD_B: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = b_ptr;
                state_nx    = EXEC;
            end
            WAIT_A: begin
                state_nx = EXEC;
            end
            EXEC: begin
                alu_src_a   = opa;
                alu_src_b   = b_eff;
                mem_wr_en   = 1'b1;
                mem_wr_addr = d_ptr;
                mem_wr_data = alu_result;
                state_nx    = (rem == MAXLEN_W'(1)) ? DONE : RD_A;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            a_ptr   <= '0;
            b_ptr   <= '0;
            d_ptr   <= '0;
            rem     <= '0;
            opa     <= '0;
            acc     <= '0;
            flags_q <= '0;
`ifdef ALU_LANES_SEQ_BCAST_EN
            bcast_q    <= 1'b0;
            first_q    <= 1'b0;
            opb_scalar <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        a_ptr <= cmd_src_a;
                        b_ptr <= cmd_src_b;
                        d_ptr <= cmd_dst;
                        rem   <= cmd_len;
                        acc   <= '0;
`ifdef ALU_LANES_SEQ_BCAST_EN
                        bcast_q <= cmd_bcast;
                        first_q <= 1'b1;
`endif
                    end
                end
                RD_B, WAIT_A: begin
                    opa <= vec_t'(mem_rd_data);
                end
                EXEC: begin
                    acc   <= acc | flags_t'(alu_flags);
                    a_ptr <= a_ptr + AW'(1);
                    d_ptr <= d_ptr + AW'(1);
                    rem   <= rem - MAXLEN_W'(1);
`ifdef ALU_LANES_SEQ_BCAST_EN
                    first_q <= 1'b0;
                    if (bcast_q && first_q) begin
                        opb_scalar <= mem_rd_data[LW-1:0];
                    end
                    if (!bcast_q) begin
                        b_ptr <= b_ptr + AW'(1);
                    end
`else
                    b_ptr <= b_ptr + AW'(1);
`endif
                end
                DONE: begin
                    flags_q <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_lanes_seq.sv
// tb/tb_alu_lanes_seq.sv - self-checking bench for alu_lanes_seq with scratch memory and add-lane ALU stub
module tb_alu_lanes_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_bcast;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic [3:0]  cmd_len;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_rd_addr, mem_wr_addr;
    logic [47:0] mem_rd_data, mem_wr_data;
    logic [47:0] alu_src_a, alu_src_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic [11:0] alu_flags;
    logic        busy, done;
    logic [11:0] flags_out;

    always #5 clk = ~clk;

    alu_lanes_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_bcast(cmd_bcast),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done), .flags_out(flags_out)
    );

    // Lane ALU stub: per-lane add, low flag row marks zero sums.
    always_comb begin
        alu_result = '0;
        alu_flags  = '0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] s;
            s = alu_src_a[8*i +: 8] + alu_src_b[8*i +: 8];
            alu_result[8*i +: 8] = s;
            alu_flags[i] = (s == 8'h00);
        end
    end

    logic [47:0] mem [256];
    logic [47:0] ref_mem [256];
    logic        tb_we, tb_clr;
    logic [7:0]  tb_waddr;
    logic [47:0] tb_wdata;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    logic [7:0]  rd_q[$], wr_q[$], exp_rd[$], exp_wr[$];
    logic [2:0]  cur_op;
    int          both_cnt = 0, ctrl_bad = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_rd_addr);
        if (mem_wr_en) begin
            wr_q.push_back(mem_wr_addr);
            if (alu_ctrl !== cur_op) ctrl_bad++;
        end
        if (mem_rd_en && mem_wr_en) both_cnt++;
        if (done) done_cnt++;
    end

    int          total = 0, bad = 0;
    logic [11:0] prev_flags = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_word(input logic [7:0] a, input logic [47:0] v);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    // Reference: beats in ascending order, each reads its operands then writes its sum.
    task automatic model_cmd(input logic [7:0] a, b, d, input logic [3:0] len, input bit bc,
                             output logic [11:0] f);
        logic [7:0]  bs;
        logic [47:0] aw, bw, r;
        bit          bce;
`ifdef ALU_LANES_SEQ_BCAST_EN
        bce = bc;
`else
        bce = 1'b0;
`endif
        exp_rd.delete(); exp_wr.delete();
        f  = '0;
        bs = '0;
        for (int i = 0; i < int'(len); i++) begin
            logic [7:0] ai, bi, di;
            ai = a + 8'(i); bi = b + 8'(i); di = d + 8'(i);
            exp_rd.push_back(ai);
            aw = ref_mem[ai];
            if (bce) begin
                if (i == 0) begin
                    exp_rd.push_back(b);
                    bs = ref_mem[b][7:0];
                end
                bw = {6{bs}};
            end else begin
                exp_rd.push_back(bi);
                bw = ref_mem[bi];
            end
            for (int l = 0; l < 6; l++) begin
                r[8*l +: 8] = aw[8*l +: 8] + bw[8*l +: 8];
                if (r[8*l +: 8] == 8'h00) f[l] = 1'b1;
            end
            ref_mem[di] = r;
            exp_wr.push_back(di);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, b, d, input logic [3:0] len,
                          input bit bc, output int lat, output logic [11:0] f_at_done);
        @(posedge clk); #1;
        rd_q.delete(); wr_q.delete();
        cur_op = op;
        cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_len = len; cmd_bcast = bc;
        cmd_valid = 1'b1;
        chk("ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1;
        f_at_done = 'x;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                f_at_done = flags_out;
                break;
            end
        end
        @(negedge clk);
    endtask

    function automatic int mem_errs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    function automatic int q_errs(input logic [7:0] x[$], input logic [7:0] y[$]);
        int n = 0;
        for (int i = 0; i < x.size() && i < y.size(); i++) if (x[i] !== y[i]) n++;
        return n;
    endfunction

    task automatic run_check(input logic [2:0] op, input logic [7:0] a, b, d, input logic [3:0] len,
                             input bit bc, output int lat, output logic [11:0] fl);
        logic [11:0] ef, fd;
        model_cmd(a, b, d, len, bc, ef);
        do_cmd(op, a, b, d, len, bc, lat, fd);
        chk("latency", lat, 3 * len + 1);
        chk("flags_held", fd, prev_flags);
        chk("flags_out", flags_out, ef);
        chk("rd_count", rd_q.size(), exp_rd.size());
        chk("rd_addr", q_errs(rd_q, exp_rd), 0);
        chk("wr_count", wr_q.size(), exp_wr.size());
        chk("wr_addr", q_errs(wr_q, exp_wr), 0);
        chk("mem_words", mem_errs(), 0);
        prev_flags = flags_out;
        fl = flags_out;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a, b, d;
        logic [3:0]  len;
        bit          bc;
        int          cyc;
        logic [11:0] fl;
    } tvec_t;

    initial begin
        tvec_t       tbl[5];
        int          lat, dc0;
        logic [11:0] fl, ef;
        logic [4:0]  rdy;
        logic [7:0]  ra, rb, rd;
        logic [3:0]  rl;
        logic [47:0] w;

        reset = 1'b1; tb_clr = 1'b1; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        cmd_len = '0; cmd_bcast = 1'b0; cur_op = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        tb_clr = 1'b0;
        chk("reset_state", {cmd_ready, busy, done, mem_rd_en, mem_wr_en, flags_out}, {5'b10000, 12'h000});
        @(negedge clk);
        reset = 1'b0;

        set_word(8'h10, 48'h060504030201);
        set_word(8'h20, 48'h010101010101);
        set_word(8'hFE, 48'h111111111111);
        set_word(8'hFF, 48'h222222222222);
        set_word(8'h00, 48'h333333333333);
        set_word(8'h01, 48'h444444444444);
        for (int i = 0; i < 4; i++) set_word(8'h40 + 8'(i), 48'h010101010101);
        set_word(8'h80, 48'h010203040506);
        set_word(8'h90, 48'h0101FD010101);
        set_word(8'h81, 48'h101112131415);
        set_word(8'h91, 48'hF00101010101);
        for (int i = 0; i < 3; i++) set_word(8'hC0 + 8'(i), 48'h010203040506);
        set_word(8'hD0, 48'hAABBCCDDEE05);

        tbl[0] = '{3'b000, 8'h10, 8'h20, 8'h30, 4'd1, 1'b0, 4,  12'h000};
        tbl[1] = '{3'b101, 8'hFE, 8'h40, 8'hFF, 4'd4, 1'b0, 13, 12'h000};
        tbl[2] = '{3'b010, 8'h80, 8'h90, 8'hA0, 4'd2, 1'b0, 7,  12'h028};
        tbl[3] = '{3'b111, 8'h50, 8'h60, 8'h70, 4'd0, 1'b0, 1,  12'h000};
        tbl[4] = '{3'b011, 8'hC0, 8'hD0, 8'hC8, 4'd3, 1'b1, 10, 12'h000};

        for (int t = 0; t < 5; t++) begin
            if (t == 3) chk("flags_before_len0", flags_out, 12'h028);
            run_check(tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].d, tbl[t].len, tbl[t].bc, lat, fl);
            chk("tbl_cycle", lat, tbl[t].cyc);
            chk("tbl_flags", fl, tbl[t].fl);
            if (t == 0) chk("single_beat_result", mem[8'h30], 48'h070605040302);
            if (t == 1) chk("wrap_last_result", mem[8'h02], 48'h151515151515);
            if (t == 4) begin
`ifdef ALU_LANES_SEQ_BCAST_EN
                chk("bcast_reads", rd_q.size(), 4);
                chk("bcast_result", mem[8'hC8], 48'h060708090A0B);
`else
                chk("nobcast_reads", rd_q.size(), 6);
                chk("nobcast_result", mem[8'hC8], 48'hABBDCFE1F30B);
`endif
            end
        end

        // Back-to-back with cmd_valid held high across both commands.
        set_word(8'hB0, 48'h0A0B0C0D0E0F);
        set_word(8'hC4, 48'h010203040506);
        set_word(8'hB1, 48'h000000000001);
        set_word(8'hC5, 48'hFFFFFFFFFFFF);
        model_cmd(8'hB0, 8'hC4, 8'hE0, 4'd1, 1'b0, ef);
        model_cmd(8'hB1, 8'hC5, 8'hE1, 4'd1, 1'b0, ef);
        @(posedge clk); #1;
        cur_op = 3'b001; cmd_op = 3'b001; cmd_bcast = 1'b0; cmd_len = 4'd1;
        cmd_src_a = 8'hB0; cmd_src_b = 8'hC4; cmd_dst = 8'hE0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_src_a = 8'hB1; cmd_src_b = 8'hC5; cmd_dst = 8'hE1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            rdy[c-1] = cmd_ready;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        @(negedge clk);
        chk("b2b_ready_pattern", rdy, 5'b10000);
        chk("b2b_second_latency", lat, 4);
        chk("b2b_flags", flags_out, ef);
        chk("b2b_mem", mem_errs(), 0);
        prev_flags = flags_out;

        // Reset during beat 1 of a three-beat command.
        for (int i = 0; i < 3; i++) begin
            set_word(8'h58 + 8'(i), rnd48());
            set_word(8'h68 + 8'(i), rnd48());
        end
        model_cmd(8'h58, 8'h68, 8'h78, 4'd1, 1'b0, ef);
        @(posedge clk); #1;
        rd_q.delete(); wr_q.delete();
        dc0 = done_cnt;
        cur_op = 3'b110; cmd_op = 3'b110; cmd_src_a = 8'h58; cmd_src_b = 8'h68;
        cmd_dst = 8'h78; cmd_len = 4'd3; cmd_bcast = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_outputs", {cmd_ready, busy, done, mem_rd_en, mem_wr_en, flags_out}, {5'b10000, 12'h000});
        @(negedge clk);
        reset = 1'b0;
        chk("reset_no_done", done_cnt - dc0, 0);
        chk("reset_wr_count", wr_q.size(), 1);
        chk("reset_mem", mem_errs(), 0);
        prev_flags = '0;
        run_check(3'b100, 8'h58, 8'h68, 8'h7C, 4'd2, 1'b0, lat, fl);

        // Random commands against the reference model.
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom); rb = 8'($urandom); rd = 8'($urandom);
            rl = 4'($urandom_range(0, 15));
            for (int i = 0; i < int'(rl); i++) set_word(ra + 8'(i), rnd48());
            for (int i = 0; i < int'(rl); i++) begin
                w = rnd48();
                for (int l = 0; l < 6; l++)
                    if ($urandom_range(0, 3) == 0) w[8*l +: 8] = 8'h00 - ref_mem[ra + 8'(i)][8*l +: 8];
                set_word(rb + 8'(i), w);
            end
            run_check(3'($urandom), ra, rb, rd, rl, 1'($urandom), lat, fl);
        end

        chk("rd_wr_overlap", both_cnt, 0);
        chk("alu_ctrl_exec", ctrl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
